// File: rtl/uart_tx_framer.sv
// Serial transmit framer: start bit, LSB-first data, optional parity, one or two
// stop bits at CLKS_PER_BIT clocks per bit, fed by a valid/ready word handshake.
module uart_tx_framer #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_out
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic                 stop_idx, stop_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bit, par_bit_n;
    logic                 par_en_q, par_en_n;
    logic                 two_stop_q, two_stop_n;
    logic                 bit_end;
    logic                 line_n;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    function automatic logic line_level(input state_t s, input logic d0, input logic p);
        logic lvl;
        lvl = 1'b1;
        case (s)
            ST_START:  lvl = 1'b0;
            ST_DATA:   lvl = d0;
            ST_PARITY: lvl = p;
            default:   lvl = 1'b1;
        endcase
        return lvl;
    endfunction

    assign bit_end = (cnt == CNT_LAST);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CNT_W'(1);
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        shreg_n    = shreg;
        par_bit_n  = par_bit;
        par_en_n   = par_en_q;
        two_stop_n = two_stop_q;

        case (state)
            ST_IDLE: begin
                cnt_n      = '0;
                bit_idx_n  = '0;
                stop_idx_n = 1'b0;
                if (tx_valid && tx_ready) begin
                    state_n    = ST_START;
                    shreg_n    = tx_data;
                    par_bit_n  = calc_parity(tx_data, parity_odd);
                    par_en_n   = parity_en;
                    two_stop_n = two_stop;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n = ST_DATA;
                    cnt_n   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shreg_n = shreg >> 1;
                    if (bit_idx == IDX_LAST) begin
                        state_n = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_n = ST_STOP;
                    cnt_n   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    // Second stop period reuses the state; stop_idx marks it.
                    if (two_stop_q && !stop_idx) begin
                        stop_idx_n = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        // Outputs are registered from the next state so the line changes on the
        // same edge as the state does.
        line_n = line_level(state_n, shreg_n[0], par_bit_n);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_out   <= 1'b1;
            tx_busy  <= 1'b0;
            tx_ready <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            stop_idx <= stop_idx_n;
            tx_out   <= line_n;
            tx_busy  <= (state_n != ST_IDLE);
            tx_ready <= (state_n == ST_IDLE);
        end
    end

    // Frame payload needs no reset: it is only consumed after a fresh accept.
    always_ff @(posedge clk) begin
        shreg      <= shreg_n;
        par_bit    <= par_bit_n;
        par_en_q   <= par_en_n;
        two_stop_q <= two_stop_n;
    end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Serial transmit framer for the APB serial peripheral; the transmit-side counterpart of the receive path's start/data/stop-bit checking. It accepts one data word per valid/ready handshake and shifts it out on a single line, LSB first. Each frame is a start bit, DATA_BITS data bits, an optional parity bit, then one or two stop bits, all at a fixed bit period of CLKS_PER_BIT clocks. It sits between the APB register/FIFO logic (upstream) and the TX pad (downstream).

## Interface
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- CLKS_PER_BIT, 16: clock cycles per serial bit; minimum 2. The baud counter is $clog2(CLKS_PER_BIT) bits wide.
- clk  input  1  system clock; all logic is on the rising edge.
- n_rst  input  1  reset, synchronous and active-low.
- tx_valid  input  1  upstream has a word to send.
- tx_data  input  DATA_BITS  word to send; sampled only on handshake.
- parity_en  input  1  1 = insert a parity bit; sampled on handshake.
- parity_odd  input  1  1 = odd parity, 0 = even parity; sampled on handshake.
- two_stop  input  1  1 = two stop bits, 0 = one stop bit; sampled on handshake.
- tx_ready  output  1  block can accept a word (registered).
- tx_busy  output  1  a frame is in progress (registered).
- tx_out  output  1  serial line; idles high (registered).

## Operation
- States and their line levels:
  - IDLE: tx_out=1.
  - START: tx_out=0.
  - DATA: tx_out = current data bit.
  - PARITY: tx_out = parity bit.
  - STOP: tx_out=1.
- Handshake:
  - A word is accepted on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_ready=1 only in IDLE.
  - On accept, the block latches tx_data, parity_en, parity_odd and two_stop into a shift register and config flags.
  - Input changes after accept have no effect on the current frame.
- Parity:
  - The parity bit is XOR of the latched data, computed at accept.
  - If parity_odd=1, the bit is inverted.
- Transitions (each bit lasts CLKS_PER_BIT cycles; the baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on every state change):
  - IDLE -> START on accept.
  - START -> DATA at the end of the bit period.
  - DATA shifts the register right at the end of each bit period; after bit DATA_BITS-1 it goes to PARITY if parity_en, else to STOP.
  - PARITY -> STOP at the end of the bit period.
  - STOP lasts 1 or 2 bit periods (per two_stop), then -> IDLE.
- Outputs:
  - tx_busy=1 in every state except IDLE.
  - tx_ready = ~tx_busy.
- tx_valid is ignored while busy; no word is lost or duplicated.
- Reset:
  - Values: tx_out=1, tx_ready=1, tx_busy=0, state IDLE, counters 0.
  - A reset during a frame aborts it: tx_out=1 at the first edge with n_rst=0. The frame is not resumed, and the latched word is discarded.
  - Reset overrides a simultaneous tx_valid: no accept occurs on an edge where n_rst=0.

## Timing
- Accept at edge E: tx_out falls to 0 and tx_ready/tx_busy change at E; the start bit occupies the cycles after E.
- Frame length: (1 + DATA_BITS + parity_en + 1 + two_stop) × CLKS_PER_BIT cycles of busy.
- tx_ready returns to 1 at the edge ending the last stop-bit period.
- Back-to-back: if tx_valid is held high, the next accept happens one cycle after tx_ready rises. The line therefore gives exactly one extra idle-high cycle between frames, so stop time is effectively +1 clock.
- Latency from accept to first data bit on tx_out: CLKS_PER_BIT cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Basic frame, no parity: CLKS_PER_BIT=4, DATA_BITS=8, parity_en=0, two_stop=0, send 0xA5.
  - tx_out, in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1.
  - tx_busy is high for exactly 40 cycles.
- Parity: send 0xA5 with parity_en=1.
  - parity_odd=0 gives parity bit 0; parity_odd=1 gives parity bit 1.
  - Send 0x07 with even parity: parity bit 1.
  - Each frame is 44 cycles.
- Two stop bits: two_stop=1, send 0x00.
  - tx_out is low for 36 cycles (start plus 8 data bits), then high for 8 cycles before tx_ready rises.
- Back-to-back and ignored valid:
  - Hold tx_valid=1 with tx_data changing every cycle. Exactly one word is accepted per frame, and each accepted value equals tx_data on its accept edge.
  - There is exactly 1 idle-high cycle between the frames.
- Reset mid-frame: assert n_rst=0 during data bit 3 for one cycle.
  - The next edge shows tx_out=1, tx_ready=1, tx_busy=0.
  - A following send of 0x3C is transmitted as a complete, correct frame.
- DATA_BITS=5 build: send 0x1F with even parity.
  - tx_out: 0,1,1,1,1,1, then parity bit 1, then stop bit 1.
  - Upper tx_data bits have no effect.
